// File: rtl/pixel_stream_out_pkg.sv
// Shared types and helpers for the pixel output path (also used by the ray generator).
package pixel_stream_out_pkg;

  // Packed pixel as produced by the shading stage: {R, G, B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Default raster size, shared with the ray generator's coordinate counters.
  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;

  // Occupancy of the single output beat register.
  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } out_stage_t;

  // Width needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the number of free slots no longer covers the in-flight margin.
  function automatic logic below_margin(input int unsigned free_slots,
                                        input int unsigned margin);
    return free_slots < margin;
  endfunction

endpackage

// File: rtl/pixel_stream_out_fifo.sv
// Synchronous FIFO with registered storage and an exact occupancy count.
// The head entry is presented straight from the storage registers so the
// consumer's own register forms the read stage without an extra cycle.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo
  import pixel_stream_out_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage write; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally; count tracks writes minus reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_out.sv
// Sink of the shading pipeline: buffers pixels and emits them as an
// AXI4-Stream video stream with tuser = start of frame, tlast = end of line.
module pixel_stream_out
  import pixel_stream_out_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned H_RES      = H_RES_DEFAULT,
  parameter int unsigned V_RES      = V_RES_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [OUT_WIDTH-1:0] shade_in,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 frame_done
);

  localparam int unsigned XW = cnt_width(H_RES);
  localparam int unsigned YW = cnt_width(V_RES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [OUT_WIDTH-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  out_stage_t           stage_q;
  out_stage_t           stage_d;
  logic                 handshake;
  logic                 load;
  logic                 drop;

  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic                 at_origin;
  logic                 at_eol;
  logic                 at_eof;

  logic [OUT_WIDTH-1:0] tdata_q;
  logic                 tuser_q;
  logic                 tlast_q;
  logic                 eof_q;
  logic                 overflow_q;
  logic                 almost_full_q;
  logic                 frame_done_q;
  logic                 af_next;

  assign m_axis_tvalid = (stage_q == STG_FULL);
  assign handshake     = m_axis_tvalid && m_axis_tready;
  // Refill whenever the beat register is free or being consumed this cycle.
  assign load          = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
  assign drop          = valid_in && fifo_full && !load;

  assign at_origin = (x_q == '0) && (y_q == '0);
  assign at_eol    = (x_q == X_LAST);
  assign at_eof    = at_eol && (y_q == Y_LAST);

  assign af_next = below_margin(FIFO_DEPTH - 32'(fifo_count), AF_MARGIN);

  assign m_axis_tdata = tdata_q;
  assign m_axis_tuser = tuser_q;
  assign m_axis_tlast = tlast_q;
  assign overflow     = overflow_q;
  assign almost_full  = almost_full_q;
  assign frame_done   = frame_done_q;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (valid_in),
    .wr_data (shade_in),
    .pop     (load),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Beat register occupancy: next state.
  always_comb begin
    stage_d = stage_q;
    if (stage_q == STG_EMPTY) begin
      if (load) begin
        stage_d = STG_FULL;
      end
    end else begin
      if (handshake && !load) begin
        stage_d = STG_EMPTY;
      end
    end
  end

  // Beat register occupancy: state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= STG_EMPTY;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Beat payload and framing; only changes on load, so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tdata_q <= '0;
      tuser_q <= 1'b0;
      tlast_q <= 1'b0;
      eof_q   <= 1'b0;
    end else if (load) begin
      tdata_q <= fifo_head;
      tuser_q <= at_origin;
      tlast_q <= at_eol;
      eof_q   <= at_eof;
    end
  end

  // Raster position of the pixel being loaded next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load) begin
      if (at_eol) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Status: sticky overflow, registered almost_full, end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      almost_full_q <= af_next;
      frame_done_q  <= handshake && eof_q;
    end
  end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Self-checking bench for pixel_stream_out: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_pixel_stream_out;

  localparam int W = 24;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 16;
  localparam int M = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] shade_in = '0;
  logic         almost_full;
  logic         overflow;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tuser;
  logic         m_axis_tlast;
  logic         frame_done;

  always #5 clk = ~clk;

  pixel_stream_out #(
    .OUT_WIDTH  (W),
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (D),
    .AF_MARGIN  (M)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .shade_in      (shade_in),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: buffered pixels, the beat on the output, status.
  logic [W-1:0] fq[$];
  logic         m_ov, m_ou, m_ol, m_oe, m_over, m_af, m_fd;
  logic [W-1:0] m_od;
  int           nload;
  bit           clean;

  // Handshaken beats observed on the DUT, for directed scenarios.
  logic [W-1:0] got[$];
  logic         gu[$];
  logic         gl[$];
  int           fd_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of the reference model, from the inputs applied at this edge.
  task automatic model_update(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
    int   sz;
    logic hs, pop, push;
    if (!r) begin
      fq.delete();
      m_ov = 0; m_ou = 0; m_ol = 0; m_oe = 0; m_od = '0;
      m_over = 0; m_af = 0; m_fd = 0;
      nload = 0; clean = 1;
      return;
    end
    sz   = fq.size();
    hs   = m_ov && rdy;
    m_fd = hs && m_oe;
    m_af = (D - sz) < M;
    pop  = (sz > 0) && (!m_ov || rdy);
    push = v && ((sz < D) || pop);
    if (v && !push) m_over = 1;
    if (pop) begin
      m_od  = fq.pop_front();
      m_ou  = (nload % (H * V)) == 0;
      m_ol  = (nload % H) == H - 1;
      m_oe  = (nload % (H * V)) == H * V - 1;
      m_ov  = 1;
      clean = 0;
      nload++;
    end else if (hs) begin
      m_ov = 0;
    end
    if (push) fq.push_back(d);
  endtask

  task automatic compare_outputs();
    chk("tvalid", m_axis_tvalid, m_ov);
    chk("almost_full", almost_full, m_af);
    chk("overflow", overflow, m_over);
    chk("frame_done", frame_done, m_fd);
    if (m_ov || clean) begin
      chk("tdata", m_axis_tdata, m_od);
      chk("tuser", m_axis_tuser, m_ou);
      chk("tlast", m_axis_tlast, m_ol);
    end
  endtask

  // Apply inputs for one cycle, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
    rst = r; valid_in = v; shade_in = d; m_axis_tready = rdy;
    if (r && m_axis_tvalid && rdy) begin
      got.push_back(m_axis_tdata);
      gu.push_back(m_axis_tuser);
      gl.push_back(m_axis_tlast);
    end
    @(posedge clk);
    model_update(r, v, d, rdy);
    #1;
    compare_outputs();
    if (frame_done) fd_cnt++;
  endtask

  task automatic clear_seen();
    got.delete(); gu.delete(); gl.delete(); fd_cnt = 0;
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
  endtask

  initial begin
    // Reset held, then the first cycle after release.
    repeat (3) step(0, 0, '0, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_overflow", overflow, 0);
    step(1, 0, '0, 0);
    chk("rel_tdata", m_axis_tdata, 0);

    // Single pixel: visible two cycles after valid_in, gone after handshake.
    step(1, 1, 24'hFF8040, 1);
    step(1, 0, '0, 1);
    chk("sp_tvalid", m_axis_tvalid, 1);
    chk("sp_tdata", m_axis_tdata, 24'hFF8040);
    chk("sp_tuser", m_axis_tuser, 1);
    chk("sp_tlast", m_axis_tlast, 0);
    step(1, 0, '0, 1);
    chk("sp_drop_valid", m_axis_tvalid, 0);

    // Backpressure: first beat held, then five in order.
    for (int i = 1; i <= 5; i++) step(1, 1, 24'(i), 0);
    step(1, 0, '0, 0);
    chk("bp_hold_valid", m_axis_tvalid, 1);
    chk("bp_hold_data", m_axis_tdata, 1);
    clear_seen();
    repeat (8) step(1, 0, '0, 1);
    chk("bp_beats", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", got[i], 24'(i + 1));

    // Framing over one 4x2 frame plus one more pixel.
    do_reset();
    clear_seen();
    for (int i = 0; i < 9; i++) step(1, 1, 24'(32'h100 + i), 1);
    repeat (4) step(1, 0, '0, 1);
    chk("fr_beats", got.size(), 9);
    for (int n = 0; n < 9 && n < got.size(); n++) begin
      chk("fr_tuser", gu[n], (n % 8) == 0);
      chk("fr_tlast", gl[n], (n % 4) == 3);
    end
    chk("fr_done_pulses", fd_cnt, 1);

    // Overflow: 20 pixels into a stalled stream, 17 survive.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 24'(k), 0);
      if (k == 13) chk("of_almost_full", almost_full, 1);
      if (k == 17) chk("of_not_yet", overflow, 0);
      if (k == 18) chk("of_set", overflow, 1);
    end
    clear_seen();
    repeat (25) step(1, 0, '0, 1);
    chk("of_beats", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++) chk("of_order", got[i], 24'(i + 1));
    chk("of_sticky", overflow, 1);

    // Full FIFO with simultaneous read and write: nothing dropped.
    do_reset();
    for (int k = 1; k <= 17; k++) step(1, 1, 24'(k), 0);
    clear_seen();
    step(1, 1, 24'h00ABCD, 1);
    chk("rw_no_drop", overflow, 0);
    step(1, 0, '0, 0);
    chk("rw_count_held", almost_full, 1);
    repeat (25) step(1, 0, '0, 1);
    chk("rw_beats", got.size(), 18);
    if (got.size() == 18) chk("rw_last", got[17], 24'h00ABCD);

    // Mid-frame reset after three beats.
    do_reset();
    clear_seen();
    for (int k = 1; k <= 5; k++) step(1, 1, 24'(32'h50 + k), 1);
    chk("mr_beats_before", got.size(), 3);
    step(0, 0, '0, 1);
    chk("mr_tvalid", m_axis_tvalid, 0);
    chk("mr_tdata", m_axis_tdata, 0);
    chk("mr_tuser", m_axis_tuser, 0);
    chk("mr_tlast", m_axis_tlast, 0);
    chk("mr_af", almost_full, 0);
    step(1, 1, 24'h777777, 1);
    step(1, 0, '0, 1);
    chk("mr_next_valid", m_axis_tvalid, 1);
    chk("mr_next_data", m_axis_tdata, 24'h777777);
    chk("mr_next_tuser", m_axis_tuser, 1);
    chk("mr_overflow", overflow, 0);
    step(1, 0, '0, 1);
    chk("mr_fifo_empty", m_axis_tvalid, 0);

    // Random traffic with varying backpressure and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 99) < 75),
             W'($urandom),
             ($urandom_range(1, 100) <= rdy_pct));
      end
    end
    repeat (30) step(1, 0, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
